irq_gateway: RTL and testbench

- Per-source interrupt gateway that sits directly upstream of the platform interrupt controller and drives its source inputs.
- Synchronises raw device interrupt lines and applies per-source polarity.
- Converts edge- or level-style requests into one clean request per source, held high until the controller signals completion.
- Edges arriving while a request is outstanding are counted, so none are lost while the controller masks the source.

---
 rtl/irq_gateway.sv | 136 +++++++++++++
 tb/tb_irq_gateway.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/irq_gateway.sv
// Per-source interrupt gateway: synchronises raw lines, applies polarity, and
// turns edge/level requests into one held request per source until completion.
module irq_gateway #(
  parameter int unsigned NUM_SOURCES = 16,
  parameter int unsigned SRC_ID_W    = 5,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_BITS    = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_SOURCES-1:0] irq_raw_i,
  input  logic [NUM_SOURCES-1:0] edge_mode_i,
  input  logic [NUM_SOURCES-1:0] polarity_i,
  input  logic                   complete_valid_i,
  input  logic [SRC_ID_W-1:0]    complete_id_i,
  input  logic [NUM_SOURCES-1:0] ovf_clear_i,
  output logic [NUM_SOURCES-1:0] req_o,
  output logic [NUM_SOURCES-1:0] overflow_o,
  output logic [NUM_SOURCES-1:0] busy_o
);

  typedef enum logic [1:0] {IDLE, REQ, HOLDOFF} state_t;

  localparam int unsigned WARM   = SYNC_STAGES + 1;
  localparam int unsigned WARM_W = $clog2(WARM + 1);

  logic [NUM_SOURCES-1:0] sync [SYNC_STAGES];
  logic [NUM_SOURCES-1:0] prev;
  logic [NUM_SOURCES-1:0] s;
  logic [NUM_SOURCES-1:0] rise;
  logic [NUM_SOURCES-1:0] ed;
  logic [NUM_SOURCES-1:0] lv;
  logic [WARM_W-1:0]      warm;
  logic                   active;

  state_t                 st     [NUM_SOURCES];
  state_t                 st_nx  [NUM_SOURCES];
  logic [CNT_BITS-1:0]    cnt    [NUM_SOURCES];
  logic [CNT_BITS-1:0]    cnt_nx [NUM_SOURCES];
  logic [NUM_SOURCES-1:0] ovf_nx;
  logic [NUM_SOURCES-1:0] req_nx;

  assign s      = sync[SYNC_STAGES-1] ^ polarity_i;
  assign rise   = s & ~prev;
  assign active = (warm == WARM_W'(WARM));
  assign ed     = {NUM_SOURCES{active}} & rise;
  assign lv     = {NUM_SOURCES{active}} & s;

  // prev keeps loading during warm-up so idle-high active-low lines settle quietly
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < SYNC_STAGES; k++) sync[k] <= '0;
      prev <= '0;
      warm <= '0;
    end else begin
      sync[0] <= irq_raw_i;
      for (int unsigned k = 1; k < SYNC_STAGES; k++) sync[k] <= sync[k-1];
      prev <= s;
      if (!active) warm <= warm + 1'b1;
    end
  end

  always_comb begin : next_state
    logic inc;
    logic dec;
    logic done;
    for (int unsigned i = 0; i < NUM_SOURCES; i++) begin
      st_nx[i]  = st[i];
      cnt_nx[i] = cnt[i];
      ovf_nx[i] = overflow_o[i] & ~ovf_clear_i[i];
      inc       = 1'b0;
      dec       = 1'b0;
      done      = 1'b0;
      if (i == 0) begin
        st_nx[i]  = IDLE;
        cnt_nx[i] = '0;
        ovf_nx[i] = 1'b0;
      end else begin
        done = complete_valid_i && (32'(complete_id_i) == i);
        inc  = edge_mode_i[i] && ed[i] && (st[i] != IDLE);
        case (st[i])
          IDLE:    if (edge_mode_i[i] ? ed[i] : lv[i]) st_nx[i] = REQ;
          REQ:     if (done) st_nx[i] = HOLDOFF;
          HOLDOFF: begin
            if (edge_mode_i[i]) begin
              // an edge landing in this very cycle is enough to re-request
              if ((cnt[i] != '0) || inc) begin
                st_nx[i] = REQ;
                dec      = 1'b1;
              end else begin
                st_nx[i] = IDLE;
              end
            end else begin
              st_nx[i] = lv[i] ? REQ : IDLE;
            end
          end
          default: st_nx[i] = IDLE;
        endcase
        if (!edge_mode_i[i]) begin
          cnt_nx[i] = '0;
        end else if (inc && !dec) begin
          if (cnt[i] == '1) ovf_nx[i] = 1'b1;
          else              cnt_nx[i] = cnt[i] + 1'b1;
        end else if (dec && !inc) begin
          cnt_nx[i] = cnt[i] - 1'b1;
        end
      end
      req_nx[i] = (st_nx[i] == REQ);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_SOURCES; i++) begin
        st[i]  <= IDLE;
        cnt[i] <= '0;
      end
      req_o      <= '0;
      overflow_o <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_SOURCES; i++) begin
        st[i]  <= st_nx[i];
        cnt[i] <= cnt_nx[i];
      end
      req_o      <= req_nx;
      overflow_o <= ovf_nx;
    end
  end

  always_comb begin
    busy_o = '0;
    for (int unsigned i = 0; i < NUM_SOURCES; i++)
      busy_o[i] = (st[i] != IDLE) || (cnt[i] != '0);
  end

endmodule

// File: tb/tb_irq_gateway.sv
// Directed, table-driven bench for irq_gateway: one vector per clock, outputs
// checked 1 time unit after the edge that sampled the vector's inputs.
module tb_irq_gateway;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] irq_raw, edge_mode, polarity, ovf_clear;
  logic        complete_valid;
  logic [4:0]  complete_id;
  logic [15:0] req, overflow, busy;

  int total = 0;
  int bad   = 0;

  irq_gateway #(
    .NUM_SOURCES(16),
    .SRC_ID_W(5),
    .SYNC_STAGES(2),
    .CNT_BITS(2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .irq_raw_i(irq_raw),
    .edge_mode_i(edge_mode),
    .polarity_i(polarity),
    .complete_valid_i(complete_valid),
    .complete_id_i(complete_id),
    .ovf_clear_i(ovf_clear),
    .req_o(req),
    .overflow_o(overflow),
    .busy_o(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] raw;
    logic        cv;
    logic [4:0]  cid;
    logic [15:0] clr;
    logic [15:0] req;
    logic [15:0] ovf;
    logic [15:0] busy;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [15:0] raw, input logic cv, input logic [4:0] cid,
                              input logic [15:0] clr, input logic [15:0] r,
                              input logic [15:0] o, input logic [15:0] b);
    vec_t v;
    v.raw = raw; v.cv = cv; v.cid = cid; v.clr = clr;
    v.req = r; v.ovf = o; v.busy = b;
    return v;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // called at a negedge; returns at the following negedge
  task automatic step(input vec_t v, input string tag);
    irq_raw        = v.raw;
    complete_valid = v.cv;
    complete_id    = v.cid;
    ovf_clear      = v.clr;
    @(posedge clk);
    #1;
    check({tag, "_req"},  req,      v.req);
    check({tag, "_ovf"},  overflow, v.ovf);
    check({tag, "_busy"}, busy,     v.busy);
    @(negedge clk);
  endtask

  initial begin
    rst_n          = 1'b0;
    edge_mode      = 16'hFFFB;  // source 2 level, others edge
    polarity       = 16'h0004;  // source 2 active-low
    irq_raw        = 16'h0004;
    complete_valid = 1'b0;
    complete_id    = '0;
    ovf_clear      = '0;

    // warm-up window with source 2 idle-high: nothing may request
    for (int k = 0; k < 5; k++) vecs.push_back(mk(16'h0004, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000));

    // source 3 edge, active-high: 3-cycle latency, completion, holdoff, idle
    vecs.push_back(mk(16'h000C, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000));
    vecs.push_back(mk(16'h0004, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000));
    vecs.push_back(mk(16'h0004, 0, 0, 0, 16'h0008, 16'h0000, 16'h0008));
    vecs.push_back(mk(16'h0004, 0, 0, 0, 16'h0008, 16'h0000, 16'h0008));
    vecs.push_back(mk(16'h0004, 0, 0, 0, 16'h0008, 16'h0000, 16'h0008));
    vecs.push_back(mk(16'h0004, 1, 3, 0, 16'h0000, 16'h0000, 16'h0008));
    vecs.push_back(mk(16'h0004, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000));
    vecs.push_back(mk(16'h0004, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000));

    // source 5: entry pulse then 5 pulses in REQ -> count 3, overflow
    vecs.push_back(mk(16'h0024, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000));
    vecs.push_back(mk(16'h0004, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000));
    for (int k = 0; k < 4; k++) begin
      vecs.push_back(mk(16'h0024, 0, 0, 0, 16'h0020, 16'h0000, 16'h0020));
      vecs.push_back(mk(16'h0004, 0, 0, 0, 16'h0020, 16'h0000, 16'h0020));
    end
    vecs.push_back(mk(16'h0024, 0, 0, 0, 16'h0020, 16'h0020, 16'h0020));
    for (int k = 0; k < 3; k++) vecs.push_back(mk(16'h0004, 0, 0, 0, 16'h0020, 16'h0020, 16'h0020));
    // three completions re-request, the fourth goes idle
    for (int k = 0; k < 3; k++) begin
      vecs.push_back(mk(16'h0004, 1, 5, 0, 16'h0000, 16'h0020, 16'h0020));
      vecs.push_back(mk(16'h0004, 0, 0, 0, 16'h0020, 16'h0020, 16'h0020));
    end
    vecs.push_back(mk(16'h0004, 1, 5, 0,       16'h0000, 16'h0020, 16'h0020));
    vecs.push_back(mk(16'h0004, 0, 0, 0,       16'h0000, 16'h0020, 16'h0000));
    vecs.push_back(mk(16'h0004, 0, 0, 16'h0020, 16'h0000, 16'h0000, 16'h0000));
    vecs.push_back(mk(16'h0004, 0, 0, 0,       16'h0000, 16'h0000, 16'h0000));

    // source 2 level, active-low
    vecs.push_back(mk(16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000));
    vecs.push_back(mk(16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000));
    vecs.push_back(mk(16'h0000, 0, 0, 0, 16'h0004, 16'h0000, 16'h0004));
    vecs.push_back(mk(16'h0000, 0, 0, 0, 16'h0004, 16'h0000, 16'h0004));
    vecs.push_back(mk(16'h0000, 1, 2, 0, 16'h0000, 16'h0000, 16'h0004));
    vecs.push_back(mk(16'h0000, 0, 0, 0, 16'h0004, 16'h0000, 16'h0004));
    for (int k = 0; k < 3; k++) vecs.push_back(mk(16'h0004, 0, 0, 0, 16'h0004, 16'h0000, 16'h0004));
    vecs.push_back(mk(16'h0004, 1, 2, 0, 16'h0000, 16'h0000, 16'h0004));
    vecs.push_back(mk(16'h0004, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000));
    vecs.push_back(mk(16'h0004, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000));

    // source 3 in REQ: ignored completions, then edge + matching completion together
    vecs.push_back(mk(16'h000C, 0, 0,  0, 16'h0000, 16'h0000, 16'h0000));
    vecs.push_back(mk(16'h0004, 0, 0,  0, 16'h0000, 16'h0000, 16'h0000));
    vecs.push_back(mk(16'h0004, 0, 0,  0, 16'h0008, 16'h0000, 16'h0008));
    vecs.push_back(mk(16'h0004, 1, 0,  0, 16'h0008, 16'h0000, 16'h0008));
    vecs.push_back(mk(16'h0004, 1, 20, 0, 16'h0008, 16'h0000, 16'h0008));
    vecs.push_back(mk(16'h0004, 1, 9,  0, 16'h0008, 16'h0000, 16'h0008));
    vecs.push_back(mk(16'h000C, 0, 0,  0, 16'h0008, 16'h0000, 16'h0008));
    vecs.push_back(mk(16'h0004, 0, 0,  0, 16'h0008, 16'h0000, 16'h0008));
    vecs.push_back(mk(16'h0004, 1, 3,  0, 16'h0000, 16'h0000, 16'h0008));
    vecs.push_back(mk(16'h0004, 0, 0,  0, 16'h0008, 16'h0000, 16'h0008));
    vecs.push_back(mk(16'h0004, 1, 3,  0, 16'h0000, 16'h0000, 16'h0008));
    vecs.push_back(mk(16'h0004, 0, 0,  0, 16'h0000, 16'h0000, 16'h0000));
    vecs.push_back(mk(16'h0004, 0, 0,  0, 16'h0000, 16'h0000, 16'h0000));

    @(negedge clk);
    check("reset_req",  req,      16'h0000);
    check("reset_ovf",  overflow, 16'h0000);
    check("reset_busy", busy,     16'h0000);
    @(negedge clk);
    rst_n = 1'b1;

    for (int k = 0; k < vecs.size(); k++) step(vecs[k], $sformatf("row%0d", k));

    // source 4 in REQ with two deferred edges, then asynchronous reset
    step(mk(16'h0014, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000), "s4_a");
    step(mk(16'h0004, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000), "s4_b");
    step(mk(16'h0014, 0, 0, 0, 16'h0010, 16'h0000, 16'h0010), "s4_c");
    step(mk(16'h0004, 0, 0, 0, 16'h0010, 16'h0000, 16'h0010), "s4_d");
    step(mk(16'h0014, 0, 0, 0, 16'h0010, 16'h0000, 16'h0010), "s4_e");
    step(mk(16'h0004, 0, 0, 0, 16'h0010, 16'h0000, 16'h0010), "s4_f");
    step(mk(16'h0004, 0, 0, 0, 16'h0010, 16'h0000, 16'h0010), "s4_g");
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_req",  req,      16'h0000);
    check("async_rst_ovf",  overflow, 16'h0000);
    check("async_rst_busy", busy,     16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++)
      step(mk(16'h0004, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000), $sformatf("post_rst%0d", k));

    // all sources active-low and idle-high across reset: warm-up keeps req low
    @(negedge clk);
    rst_n    = 1'b0;
    polarity = 16'hFFFF;
    irq_raw  = 16'hFFFF;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 20; k++)
      step(mk(16'hFFFF, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000), $sformatf("warm%0d", k));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
